// File: rtl/lfsr_period.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_period
//  Description : Parametrised Galois LFSR with seed load, step enable and a
//                period measurement engine. On start it captures the current
//                state and counts enabled steps until that state recurs
//                (done) or 2^WIDTH steps pass without recurrence (timeout).
//                Optional build macro LFSR_ZERO_GUARD_EN replaces a loaded
//                all-zero seed with 1 so the register never locks up via load.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_period #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter int               CNT_W = WIDTH + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic             start,
    output logic [WIDTH-1:0] state_out,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] period
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_TMO  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_full = c_one << WIDTH;   // 2^WIDTH steps

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_lfsr;
    logic [WIDTH-1:0]   w_lfsr_nxt;
    logic [WIDTH-1:0]   r_ref;
    logic [WIDTH-1:0]   w_ref_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   w_period_nxt;

    logic [WIDTH-1:0]   w_step;
    logic [WIDTH-1:0]   w_seed_eff;
    logic               w_capture;
    logic [WIDTH-1:0]   w_ref_cur;
    logic [CNT_W-1:0]   w_cnt_inc;

    // One Galois step: shift right, fold the taps in when a one drops out.
    assign w_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

`ifdef LFSR_ZERO_GUARD_EN
    // An all-zero seed would park the register in its lockup state.
    assign w_seed_eff = (seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;
`else
    assign w_seed_eff = seed;
`endif

    // A start outside RUN captures the reference; an en on the same edge is
    // then already step 1, so compare against the freshly captured state.
    assign w_capture = start && (r_state != ST_RUN);
    assign w_ref_cur = w_capture ? r_lfsr : r_ref;
    assign w_cnt_inc = (w_capture ? '0 : r_count) + c_one;

    // Next-state and datapath update; load overrides everything else.
    always_comb begin
        w_state_nxt  = r_state;
        w_lfsr_nxt   = r_lfsr;
        w_ref_nxt    = r_ref;
        w_count_nxt  = r_count;
        w_period_nxt = r_period;
        if (load) begin
            w_lfsr_nxt   = w_seed_eff;
            w_state_nxt  = ST_IDLE;
            w_period_nxt = '0;
        end else begin
            if (en) begin
                w_lfsr_nxt = w_step;
            end
            if (w_capture) begin
                w_ref_nxt    = r_lfsr;
                w_count_nxt  = '0;
                w_period_nxt = '0;
                w_state_nxt  = ST_RUN;
            end
            if ((r_state == ST_RUN || w_capture) && en) begin
                w_count_nxt = w_cnt_inc;
                if (w_step == w_ref_cur) begin
                    w_state_nxt  = ST_DONE;
                    w_period_nxt = w_cnt_inc;
                end else if (w_cnt_inc == c_full) begin
                    w_state_nxt  = ST_TMO;
                    w_period_nxt = c_full;
                end
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_lfsr   <= {{(WIDTH-1){1'b0}}, 1'b1};
            r_ref    <= '0;
            r_count  <= '0;
            r_period <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_ref    <= w_ref_nxt;
            r_count  <= w_count_nxt;
            r_period <= w_period_nxt;
        end
    end

    // Flags decode straight from the registered state.
    assign state_out = r_lfsr;
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign timeout   = (r_state == ST_TMO);
    assign period    = r_period;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_period.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_period
//  Description : Self-checking bench for lfsr_period. Three instances:
//                WIDTH=4/TAPS=C, WIDTH=4/TAPS=3 and the 16-bit default, the
//                last measuring its full period in the background.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_period;

    localparam logic [3:0]  TAPS_A = 4'hC;
    localparam logic [3:0]  TAPS_B = 4'h3;
    localparam logic [15:0] TAPS_C = 16'hB400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // 4-bit instances, index 0 = TAPS_A, index 1 = TAPS_B
    logic       rst_v [2];
    logic       ld    [2];
    logic       en_v  [2];
    logic       st    [2];
    logic [3:0] sd    [2];
    logic [3:0] so    [2];
    logic       bz    [2];
    logic       dn    [2];
    logic       tmo   [2];
    logic [4:0] per   [2];

    // 16-bit instance
    logic        c_rst, c_ld, c_en, c_st;
    logic [15:0] c_sd, c_so;
    logic        c_bz, c_dn, c_to;
    logic [16:0] c_per;

    lfsr_period #(.WIDTH(4), .TAPS(TAPS_A), .CNT_W(5)) u_a (
        .clk(clk), .reset(rst_v[0]), .load(ld[0]), .seed(sd[0]), .en(en_v[0]),
        .start(st[0]), .state_out(so[0]), .busy(bz[0]), .done(dn[0]),
        .timeout(tmo[0]), .period(per[0])
    );

    lfsr_period #(.WIDTH(4), .TAPS(TAPS_B), .CNT_W(5)) u_b (
        .clk(clk), .reset(rst_v[1]), .load(ld[1]), .seed(sd[1]), .en(en_v[1]),
        .start(st[1]), .state_out(so[1]), .busy(bz[1]), .done(dn[1]),
        .timeout(tmo[1]), .period(per[1])
    );

    lfsr_period u_c (
        .clk(clk), .reset(c_rst), .load(c_ld), .seed(c_sd), .en(c_en),
        .start(c_st), .state_out(c_so), .busy(c_bz), .done(c_dn),
        .timeout(c_to), .period(c_per)
    );

    // Reference step rule straight from the definition.
    function automatic logic [31:0] ref_step(input logic [31:0] taps, input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

    // Number of steps for s to recur, 0 if it never does within 2^w steps.
    function automatic int ref_period(input int w, input logic [31:0] taps, input logic [31:0] s);
        logic [31:0] cur;
        cur = s;
        for (int i = 1; i <= (1 << w); i++) begin
            cur = ref_step(taps, cur);
            if (cur == s) return i;
        end
        return 0;
    endfunction

    function automatic logic [3:0] eff_seed(input logic [3:0] s);
`ifdef LFSR_ZERO_GUARD_EN
        return (s == 4'h0) ? 4'h1 : s;
`else
        return s;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load s, start, then step with en held (0), toggled (1) or random (2).
    task automatic run4(input int i, input logic [3:0] s, input int mode, input string tag);
        logic [31:0] taps, m;
        int p, target, steps, cyc;
        bit e;
        taps = (i == 0) ? 32'(TAPS_A) : 32'(TAPS_B);
        ld[i] = 1'b1; sd[i] = s; st[i] = 1'b0; en_v[i] = 1'b0;
        tick;
        ld[i] = 1'b0;
        m = 32'(eff_seed(s));
        chk({tag, "/load"}, 32'(so[i]), m);
        chk({tag, "/load_period"}, 32'(per[i]), 32'd0);
        p = ref_period(4, taps, m);
        target = (p == 0) ? 16 : p;
        st[i] = 1'b1;
        steps = 0;
        cyc = 0;
        while (steps < target && cyc < 200) begin
            case (mode)
                0:       e = 1'b1;
                1:       e = (cyc % 2 == 0);
                default: e = 1'($urandom % 2);
            endcase
            en_v[i] = e;
            tick;
            st[i] = 1'b0;
            if (e) begin
                m = ref_step(taps, m);
                steps++;
            end
            cyc++;
            chk({tag, "/state"}, 32'(so[i]), m);
            if (steps < target) chk({tag, "/busy"}, 32'(bz[i]), 32'd1);
        end
        en_v[i] = 1'b0;
        chk({tag, "/done"},    32'(dn[i]),  32'(p != 0));
        chk({tag, "/timeout"}, 32'(tmo[i]), 32'(p == 0));
        chk({tag, "/period"},  32'(per[i]), 32'(target));
        chk({tag, "/idle"},    32'(bz[i]),  32'd0);
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; ld[i] = 1'b0; en_v[i] = 1'b0; st[i] = 1'b0; sd[i] = 4'h0;
        end
        c_rst = 1'b1; c_ld = 1'b0; c_en = 1'b0; c_st = 1'b0; c_sd = 16'h0;
        tick;
        tick;
        chk("rst/state",   32'(so[0]),  32'h1);
        chk("rst/busy",    32'(bz[0]),  32'd0);
        chk("rst/done",    32'(dn[0]),  32'd0);
        chk("rst/timeout", 32'(tmo[0]), 32'd0);
        chk("rst/period",  32'(per[0]), 32'd0);
        chk("rst16/state", 32'(c_so),   32'h1);
        rst_v[0] = 1'b0; rst_v[1] = 1'b0; c_rst = 1'b0;
        tick;

        // 16-bit full period runs in the background while the 4-bit tests go
        c_ld = 1'b1; c_sd = 16'h0001;
        tick;
        c_ld = 1'b0;
        chk("w16/load", 32'(c_so), 32'h1);
        c_st = 1'b1; c_en = 1'b1;
        tick;
        c_st = 1'b0;
        chk("w16/step1", 32'(c_so), ref_step(32'(TAPS_C), 32'h1));
        chk("w16/busy",  32'(c_bz), 32'd1);

        // directed runs
        run4(0, 4'h1, 0, "a_seed1");
        run4(0, 4'h1, 1, "a_toggle");
        run4(1, 4'h8, 0, "b_seed8");
        run4(0, 4'h0, 0, "a_zero");

        // randomized seeds and enable patterns
        for (int k = 0; k < 4; k++) run4(0, 4'($urandom_range(0, 15)), 2, "a_rand");
        for (int k = 0; k < 3; k++) run4(1, 4'($urandom_range(0, 15)), 2, "b_rand");

        // load aborts RUN and wins over en
        ld[0] = 1'b1; sd[0] = 4'h1;
        tick;
        ld[0] = 1'b0; st[0] = 1'b1; en_v[0] = 1'b1;
        tick;
        st[0] = 1'b0;
        repeat (4) tick;
        chk("abort/busy_before", 32'(bz[0]), 32'd1);
        ld[0] = 1'b1; sd[0] = 4'h5;
        tick;
        ld[0] = 1'b0; en_v[0] = 1'b0;
        chk("abort/state",  32'(so[0]),  32'h5);
        chk("abort/busy",   32'(bz[0]),  32'd0);
        chk("abort/period", 32'(per[0]), 32'd0);
        chk("abort/done",   32'(dn[0]),  32'd0);

        // load wins over start and en on the same edge
        ld[0] = 1'b1; sd[0] = 4'h9; st[0] = 1'b1; en_v[0] = 1'b1;
        tick;
        ld[0] = 1'b0; st[0] = 1'b0; en_v[0] = 1'b0;
        chk("ldst/state", 32'(so[0]), 32'h9);
        chk("ldst/busy",  32'(bz[0]), 32'd0);

        // asynchronous reset in the middle of a measurement
        st[0] = 1'b1; en_v[0] = 1'b1;
        tick;
        st[0] = 1'b0;
        tick;
        tick;
        chk("areset/busy_before", 32'(bz[0]), 32'd1);
        #2;
        rst_v[0] = 1'b1;
        #1;
        chk("areset/state",   32'(so[0]),  32'h1);
        chk("areset/busy",    32'(bz[0]),  32'd0);
        chk("areset/done",    32'(dn[0]),  32'd0);
        chk("areset/timeout", 32'(tmo[0]), 32'd0);
        chk("areset/period",  32'(per[0]), 32'd0);
        en_v[0] = 1'b0;
        rst_v[0] = 1'b0;
        tick;

        // collect the 16-bit result
        guard = 0;
        while (!c_dn && guard < 70000) begin
            tick;
            guard++;
        end
        c_en = 1'b0;
        chk("w16/done",    32'(c_dn),  32'd1);
        chk("w16/timeout", 32'(c_to),  32'd0);
        chk("w16/period",  32'(c_per), 32'(ref_period(16, 32'(TAPS_C), 32'h1)));
        chk("w16/state",   32'(c_so),  32'h1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
